// File: rtl/equiv_pkg.sv
// Shared definitions for the equivalence stimulus generator.
// Holds the sequencer state encoding, the LFSR width and Galois tap mask,
// and the LFSR bit-slice boundaries that feed wire0..wire3, so that the
// generator, the harness and any checker agree on one mapping.
package equiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam int          LFSR_W    = 64;
    // Taps 64,63,61,60 for a right-shifting Galois LFSR (maximal length).
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    localparam int W0_LSB = 0;
    localparam int W0_MSB = 17;
    localparam int W1_LSB = 18;
    localparam int W1_MSB = 31;
    localparam int W2_LSB = 32;
    localparam int W2_MSB = 41;
    localparam int W3_LSB = 42;
    localparam int W3_MSB = 62;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/equiv_lfsr64.sv
// 64-bit Galois LFSR used as the stimulus source.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - synchronous active-low reset, clears the state to zero
//   load_i   - load seed_i (DEF_SEED substituted when seed_i is zero)
//   adv_i    - advance one step; ignored while load_i is high
//   seed_i   - seed value
//   state_o  - current LFSR state
module equiv_lfsr64
    import equiv_pkg::*;
#(
    parameter logic [63:0] DEF_SEED = 64'h0123_4567_89AB_CDEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else if (load_i) begin
            // An all-zero state would lock the LFSR forever.
            lfsr_q <= (seed_i == '0) ? DEF_SEED : seed_i;
        end else if (adv_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/equiv_stim_gen.sv
// Stimulus generator feeding the equivalence harness.
// Each vector is taken from a 64-bit LFSR, held for SETTLE cycles, then a
// one-cycle cmp_en strobe tells the harness to compare. A run of num_vec
// vectors is started by start and ends with a one-cycle done pulse; stop
// aborts a run early and sets the aborted level.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   start, stop      - run request (IDLE only) / abort request (busy states)
//   seed_in, num_vec - seed and vector count captured on accepted start
//   wire0..wire3     - stimulus slices of the LFSR
//   cmp_en           - compare strobe, one cycle per vector
//   busy, done       - run in progress / end-of-run pulse
//   aborted          - last run ended through stop
//   vec_idx          - index of the vector currently applied
module equiv_stim_gen
    import equiv_pkg::*;
#(
    parameter int unsigned SETTLE   = 2,
    parameter logic [63:0] DEF_SEED = 64'h0123_4567_89AB_CDEF,
    parameter int          CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [63:0]         seed_in,
    input  logic [CNT_W-1:0]    num_vec,
    output logic [17:0]         wire0,
    output logic signed [13:0]  wire1,
    output logic signed [9:0]   wire2,
    output logic signed [20:0]  wire3,
    output logic                cmp_en,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [CNT_W-1:0]    vec_idx
);

    localparam logic [7:0] SETTLE_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);

    state_e              state_q;
    logic [7:0]          cnt_q;
    logic [CNT_W-1:0]    num_q;
    logic [CNT_W-1:0]    vec_idx_q;
    logic [17:0]         wire0_q;
    logic signed [13:0]  wire1_q;
    logic signed [9:0]   wire2_q;
    logic signed [20:0]  wire3_q;
    logic                busy_q;
    logic                aborted_q;

    logic [LFSR_W-1:0]   lfsr;
    logic                lfsr_load;
    logic                lfsr_adv;
    logic                unused_lfsr_msb;

    assign lfsr_load       = (state_q == ST_IDLE) && start;
    assign lfsr_adv        = (state_q == ST_APPLY) && !stop;
    assign unused_lfsr_msb = lfsr[LFSR_W-1];

    equiv_lfsr64 #(
        .DEF_SEED (DEF_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (lfsr_load),
        .adv_i   (lfsr_adv),
        .seed_i  (seed_in),
        .state_o (lfsr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            vec_idx_q <= '0;
            wire0_q   <= '0;
            wire1_q   <= '0;
            wire2_q   <= '0;
            wire3_q   <= '0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_q     <= num_vec;
                        vec_idx_q <= '0;
                        aborted_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= (num_vec == '0) ? ST_DONE : ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (stop) begin
                        aborted_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        wire0_q <= lfsr[W0_MSB:W0_LSB];
                        wire1_q <= $signed(lfsr[W1_MSB:W1_LSB]);
                        wire2_q <= $signed(lfsr[W2_MSB:W2_LSB]);
                        wire3_q <= $signed(lfsr[W3_MSB:W3_LSB]);
                        cnt_q   <= '0;
                        state_q <= (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (stop) begin
                        aborted_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_CHECK: begin
                    // stop outranks both the next-vector and end-of-run paths.
                    if (stop) begin
                        aborted_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (vec_idx_q == num_q - CNT_W'(1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        vec_idx_q <= vec_idx_q + CNT_W'(1);
                        state_q   <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobe is withheld when an abort lands on the compare cycle.
    assign cmp_en  = (state_q == ST_CHECK) && !stop;
    assign done    = (state_q == ST_DONE);
    assign busy    = busy_q;
    assign aborted = aborted_q;
    assign vec_idx = vec_idx_q;
    assign wire0   = wire0_q;
    assign wire1   = wire1_q;
    assign wire2   = wire2_q;
    assign wire3   = wire3_q;

endmodule

// File: tb/tb_equiv_stim_gen.sv
// Directed bench for equiv_stim_gen: one instance with SETTLE=2, one with
// SETTLE=0. Each run records outputs per cycle (cycle 1 = first cycle after
// the start-accept edge) and the recorded values are compared to
// hand-computed expectations.
module tb_equiv_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        stop = 1'b0;
    logic [63:0] seed_in = '0;
    logic [15:0] num_vec = '0;

    logic [17:0]        a_w0, b_w0;
    logic signed [13:0] a_w1, b_w1;
    logic signed [9:0]  a_w2, b_w2;
    logic signed [20:0] a_w3, b_w3;
    logic               a_cmp, b_cmp, a_busy, b_busy, a_done, b_done, a_abt, b_abt;
    logic [15:0]        a_idx, b_idx;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] r_w0[64], r_w1[64], r_w2[64], r_w3[64], r_idx[64];
    logic        r_cmp[64], r_done[64], r_busy[64], r_abt[64];

    always #5 clk = ~clk;

    equiv_stim_gen #(.SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop),
        .seed_in(seed_in), .num_vec(num_vec),
        .wire0(a_w0), .wire1(a_w1), .wire2(a_w2), .wire3(a_w3),
        .cmp_en(a_cmp), .busy(a_busy), .done(a_done), .aborted(a_abt),
        .vec_idx(a_idx)
    );

    equiv_stim_gen #(.SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop),
        .seed_in(seed_in), .num_vec(num_vec),
        .wire0(b_w0), .wire1(b_w1), .wire2(b_w2), .wire3(b_w3),
        .cmp_en(b_cmp), .busy(b_busy), .done(b_done), .aborted(b_abt),
        .vec_idx(b_idx)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts a run on instance sel (0 = SETTLE 2, 1 = SETTLE 0) and records
    // ncyc cycles. start stays high while c < hold; stop is high in cycle
    // stop_at; rst_n is low in cycle rst_at (0 disables).
    task automatic run(input int sel, input logic [63:0] seed, input logic [15:0] n,
                       input int ncyc, input int hold, input int stop_at, input int rst_at);
        @(negedge clk);
        seed_in = seed;
        num_vec = n;
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (sel == 0) start_a = (c < hold); else start_b = (c < hold);
            stop  = (c == stop_at);
            rst_n = !(c == rst_at);
            #1;
            if (sel == 0) begin
                r_cmp[c] = a_cmp; r_done[c] = a_done; r_busy[c] = a_busy; r_abt[c] = a_abt;
                r_idx[c] = 64'(a_idx); r_w0[c] = 64'(a_w0);
                r_w1[c] = 64'($unsigned(a_w1)); r_w2[c] = 64'($unsigned(a_w2));
                r_w3[c] = 64'($unsigned(a_w3));
            end else begin
                r_cmp[c] = b_cmp; r_done[c] = b_done; r_busy[c] = b_busy; r_abt[c] = b_abt;
                r_idx[c] = 64'(b_idx); r_w0[c] = 64'(b_w0);
                r_w1[c] = 64'($unsigned(b_w1)); r_w2[c] = 64'($unsigned(b_w2));
                r_w3[c] = 64'($unsigned(b_w3));
            end
        end
        stop  = 1'b0;
        rst_n = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    function automatic int count_cmp(input int lo, input int hi);
        int k = 0;
        for (int c = lo; c <= hi; c++) if (r_cmp[c]) k++;
        return k;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int k = 0;
        for (int c = lo; c <= hi; c++) if (r_done[c]) k++;
        return k;
    endfunction

    logic [63:0] defs;

    initial begin
        defs = 64'h0123_4567_89AB_CDEF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_cmp", a_cmp, 0);
        check("rst_abt", a_abt, 0);
        check("rst_idx", a_idx, 0);
        check("rst_w0", a_w0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // num_vec = 0: done immediately, no strobes, wires untouched
        run(0, 64'd3, 16'd0, 4, 1, 0, 0);
        check("n0_busy_c1", r_busy[1], 1);
        check("n0_busy_c2", r_busy[2], 0);
        check("n0_done_c1", r_done[1], 1);
        check("n0_done_cnt", count_done(1, 4), 1);
        check("n0_cmp_cnt", count_cmp(1, 4), 0);
        check("n0_w0", r_w0[4], 0);
        check("n0_w3", r_w3[4], 0);

        // seed 1, two vectors, SETTLE 2
        run(0, 64'd1, 16'd2, 12, 1, 0, 0);
        check("t1_cmp_c4", r_cmp[4], 1);
        check("t1_cmp_c8", r_cmp[8], 1);
        check("t1_cmp_cnt", count_cmp(1, 12), 2);
        check("t1_done_c9", r_done[9], 1);
        check("t1_done_cnt", count_done(1, 12), 1);
        check("t1_v0_w0", r_w0[4], 64'd1);
        check("t1_v0_w1", r_w1[4], 0);
        check("t1_v0_w3", r_w3[4], 0);
        check("t1_v0_idx", r_idx[4], 0);
        check("t1_v1_w0", r_w0[8], 0);
        check("t1_v1_w2", r_w2[8], 0);
        check("t1_v1_w3", r_w3[8], 64'h16_0000);
        check("t1_v1_idx", r_idx[8], 1);
        check("t1_busy_c9", r_busy[9], 1);
        check("t1_busy_c10", r_busy[10], 0);
        check("t1_w3_hold", r_w3[11], 64'h16_0000);

        // zero seed falls back to DEF_SEED
        run(0, 64'd0, 16'd1, 6, 1, 0, 0);
        check("z_cmp_c4", r_cmp[4], 1);
        check("z_w0", r_w0[4], 64'(defs[17:0]));
        check("z_w1", r_w1[4], 64'(defs[31:18]));
        check("z_w2", r_w2[4], 64'(defs[41:32]));
        check("z_w3", r_w3[4], 64'(defs[62:42]));
        check("z_done_c5", r_done[5], 1);

        // SETTLE 0, three vectors, start held high while busy
        run(1, 64'd1, 16'd3, 10, 7, 0, 0);
        check("s0_cmp_c2", r_cmp[2], 1);
        check("s0_cmp_c4", r_cmp[4], 1);
        check("s0_cmp_c6", r_cmp[6], 1);
        check("s0_cmp_cnt", count_cmp(1, 10), 3);
        check("s0_done_c7", r_done[7], 1);
        check("s0_done_cnt", count_done(1, 10), 1);
        check("s0_idx_c6", r_idx[6], 2);
        check("s0_busy_c8", r_busy[8], 0);
        check("s0_v1_w0", r_w0[4], 0);

        // stop in the CHECK cycle of vector 5
        run(0, 64'd7, 16'd100, 30, 1, 24, 0);
        check("sp_cmp_c20", r_cmp[20], 1);
        check("sp_cmp_c24", r_cmp[24], 0);
        check("sp_done_c25", r_done[25], 1);
        check("sp_abt_c25", r_abt[25], 1);
        check("sp_idx_c25", r_idx[25], 5);
        check("sp_done_cnt", count_done(1, 30), 1);
        check("sp_abt_c30", r_abt[30], 1);

        // reset during SETTLE of vector 3
        run(0, 64'd9, 16'd10, 20, 1, 0, 14);
        check("rs_abt_c1", r_abt[1], 0);
        check("rs_idx_c14", r_idx[14], 3);
        check("rs_busy_c15", r_busy[15], 0);
        check("rs_w0_c15", r_w0[15], 0);
        check("rs_w3_c15", r_w3[15], 0);
        check("rs_idx_c15", r_idx[15], 0);
        check("rs_cmp_cnt", count_cmp(15, 20), 0);
        check("rs_done_cnt", count_done(1, 20), 0);

        // a fresh run after the reset behaves normally
        run(0, 64'd1, 16'd1, 6, 1, 0, 0);
        check("rr_cmp_c4", r_cmp[4], 1);
        check("rr_w0", r_w0[4], 64'd1);
        check("rr_done_c5", r_done[5], 1);
        check("rr_abt_c5", r_abt[5], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
